// File: rtl/core_xfade_sel.sv
// Glitch-free core switcher: fades the active core's four channels to silence,
// swaps to the requested core, then fades back in, one gain step per sample tick.
module core_xfade_sel #(
   parameter int W         = 16,
   parameter int N_CORES   = 4,
   parameter int FADE_LOG2 = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sample_clk,
   input  logic                     sel_valid,
   output logic                     sel_ready,
   input  logic [1:0]               sel_core,
   input  logic [N_CORES*4*W-1:0]   core_out,
   output logic [W-1:0]             sample_out0,
   output logic [W-1:0]             sample_out1,
   output logic [W-1:0]             sample_out2,
   output logic [W-1:0]             sample_out3,
   output logic [1:0]               active_core,
   output logic                     busy
);

   localparam int GW = FADE_LOG2 + 1;
   localparam int PW = W + FADE_LOG2 + 2;
   localparam logic [GW-1:0] GMAX   = {1'b1, {FADE_LOG2{1'b0}}};
   localparam logic [GW-1:0] G_ONE  = {{FADE_LOG2{1'b0}}, 1'b1};
   localparam logic [2:0]    NC_LIM = 3'(N_CORES);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FADE_OUT = 2'd1,
      SWAP     = 2'd2,
      FADE_IN  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   gain_q, gain_d;
   logic [1:0]      active_q, active_d;
   logic [1:0]      pend_q, pend_d;
   logic            sclk_q;
   logic            tick_s;
   logic            ignore_req_s;
   logic [W-1:0]    out_q [4];
   logic [W-1:0]    out_d [4];
   logic [W-1:0]    lane_s [4][4];

   // Signed sample times unsigned gain at full precision, floored by the shift.
   function automatic logic [W-1:0] scale_sample(input logic [W-1:0] s, input logic [GW-1:0] g);
      logic signed [PW-1:0] prod;
      prod = $signed({{(FADE_LOG2+2){s[W-1]}}, s}) * $signed({{(W+1){1'b0}}, g});
      return W'(prod >>> FADE_LOG2);
   endfunction

   // Unpack the flat core bus; absent cores read as silence.
   for (genvar k = 0; k < 4; k++) begin : g_core
      for (genvar c = 0; c < 4; c++) begin : g_chan
         if (k < N_CORES) begin : g_real
            assign lane_s[k][c] = core_out[(k*4+c)*W +: W];
         end else begin : g_absent
            assign lane_s[k][c] = '0;
         end
      end
   end

   assign tick_s       = sample_clk & ~sclk_q;
   assign ignore_req_s = (sel_core == active_q) || ({1'b0, sel_core} >= NC_LIM);
   assign sel_ready    = (state_q == RUN);
   assign busy         = (state_q != RUN);
   assign active_core  = active_q;
   assign sample_out0  = out_q[0];
   assign sample_out1  = out_q[1];
   assign sample_out2  = out_q[2];
   assign sample_out3  = out_q[3];

   // Fade sequencing and per-tick output scaling.
   always_comb begin
      state_d  = state_q;
      gain_d   = gain_q;
      active_d = active_q;
      pend_d   = pend_q;
      for (int c = 0; c < 4; c++) out_d[c] = out_q[c];
      case (state_q)
         RUN: begin
            if (sel_valid && !ignore_req_s) begin
               pend_d  = sel_core;
               state_d = FADE_OUT;
            end else begin
               state_d = RUN;
            end
         end
         FADE_OUT: begin
            if (tick_s) begin
               gain_d = gain_q - G_ONE;
               if (gain_d == '0) state_d = SWAP;
               else              state_d = FADE_OUT;
            end else begin
               state_d = FADE_OUT;
            end
         end
         SWAP: begin
            active_d = pend_q;
            state_d  = FADE_IN;
         end
         FADE_IN: begin
            if (tick_s) begin
               gain_d = gain_q + G_ONE;
               if (gain_d == GMAX) state_d = RUN;
               else                state_d = FADE_IN;
            end else begin
               state_d = FADE_IN;
            end
         end
         default: begin
            state_d = FADE_IN;
            gain_d  = '0;
         end
      endcase
      // Scale with the old core and post-update gain so an accept on a tick stays unscaled.
      if (tick_s) begin
         for (int c = 0; c < 4; c++) out_d[c] = scale_sample(lane_s[active_q][c], gain_d);
      end else begin
         for (int c = 0; c < 4; c++) out_d[c] = out_q[c];
      end
   end

   // State, gain, routing and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= FADE_IN;
         gain_q   <= '0;
         active_q <= 2'd0;
         pend_q   <= 2'd0;
         sclk_q   <= 1'b0;
         for (int c = 0; c < 4; c++) out_q[c] <= '0;
      end else begin
         state_q  <= state_d;
         gain_q   <= gain_d;
         active_q <= active_d;
         pend_q   <= pend_d;
         sclk_q   <= sample_clk;
         for (int c = 0; c < 4; c++) out_q[c] <= out_d[c];
      end
   end

endmodule

// File: tb/tb_core_xfade_sel.sv
// Randomized bench for core_xfade_sel against a fade-progress reference model.
module tb_core_xfade_sel;

   localparam int W    = 16;
   localparam int NC   = 3;
   localparam int FL   = 6;
   localparam int GMAX = 64;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 sample_clk;
   logic                 sel_valid;
   logic                 sel_ready;
   logic [1:0]           sel_core;
   logic [NC*4*W-1:0]    core_out;
   logic [W-1:0]         so0, so1, so2, so3;
   logic [1:0]           active_core;
   logic                 busy;
   logic signed [W-1:0]  vals [NC][4];

   int n_checks = 0;
   int n_errors = 0;

   // Model: a fade is a count of ticks done (0..2*GMAX) with one swap cycle at the midpoint.
   bit m_busy, m_swapped, m_prev;
   int m_done, m_core, m_pend, m_accepts;
   int m_out [4];

   core_xfade_sel #(.W(W), .N_CORES(NC), .FADE_LOG2(FL)) dut (
      .clk(clk), .rst(rst), .sample_clk(sample_clk),
      .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_core(sel_core),
      .core_out(core_out),
      .sample_out0(so0), .sample_out1(so1), .sample_out2(so2), .sample_out3(so3),
      .active_core(active_core), .busy(busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      core_out = '0;
      for (int k = 0; k < NC; k++)
         for (int c = 0; c < 4; c++)
            core_out[(k*4+c)*W +: W] = vals[k][c];
   end

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int model_gain();
      if (!m_busy)           return GMAX;
      else if (m_done <= GMAX) return GMAX - m_done;
      else                   return m_done - GMAX;
   endfunction

   function automatic int floor_scale(input int v, input int g);
      int p, q;
      p = v * g;
      q = p / GMAX;
      if (p < 0 && (p % GMAX) != 0) q = q - 1;
      return q;
   endfunction

   task automatic model_reset();
      m_busy = 1; m_swapped = 1; m_done = GMAX; m_prev = 0;
      m_core = 0; m_pend = 0;
      for (int c = 0; c < 4; c++) m_out[c] = 0;
   endtask

   task automatic model_edge();
      bit tick;
      int old_core;
      if (rst) begin
         model_reset();
         return;
      end
      tick = sample_clk && !m_prev;
      m_prev = sample_clk;
      old_core = m_core;
      if (!m_busy) begin
         if (sel_valid) begin
            m_accepts++;
            if (int'(sel_core) != m_core && int'(sel_core) < NC) begin
               m_pend = sel_core; m_busy = 1; m_done = 0; m_swapped = 0;
            end
         end
      end else if (m_done == GMAX && !m_swapped) begin
         m_core = m_pend; m_swapped = 1;
      end else if (tick) begin
         m_done++;
         if (m_done == 2*GMAX) m_busy = 0;
      end
      if (tick)
         for (int c = 0; c < 4; c++) m_out[c] = floor_scale(int'(vals[old_core][c]), model_gain());
   endtask

   task automatic compare_all();
      check_eq("out0", int'($signed(so0)), m_out[0]);
      check_eq("out1", int'($signed(so1)), m_out[1]);
      check_eq("out2", int'($signed(so2)), m_out[2]);
      check_eq("out3", int'($signed(so3)), m_out[3]);
      check_eq("active_core", int'(active_core), m_core);
      check_eq("busy", int'(busy), int'(m_busy));
      check_eq("sel_ready", int'(sel_ready), int'(!m_busy));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         sample_clk = 1'b0; step();
         sample_clk = 1'b1; step();
      end
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 2000 && m_busy; i++) begin
         sample_clk = ~sample_clk; step();
      end
      if (m_busy) check_eq("idle_timeout", 0, 1);
   endtask

   initial begin
      int a0;
      rst = 1'b1; sample_clk = 1'b0; sel_valid = 1'b0; sel_core = 2'd0; m_accepts = 0;
      for (int c = 0; c < 4; c++) begin
         vals[0][c] = 16'sd1000;
         vals[2][c] = -16'sd2000;
      end
      vals[1][0] = 16'sd300; vals[1][1] = -16'sd300; vals[1][2] = 16'sd7; vals[1][3] = -16'sd7;
      model_reset();
      repeat (3) step();
      check_eq("rst_busy", int'(busy), 1);
      check_eq("rst_ready", int'(sel_ready), 0);
      rst = 1'b0;

      // Power-up fade-in of core 0
      tick_n(1);
      check_eq("first_tick", int'($signed(so0)), 15);
      tick_n(63);
      check_eq("fadein_done", int'($signed(so0)), 1000);
      check_eq("run_busy", int'(busy), 0);
      check_eq("run_ready", int'(sel_ready), 1);

      // Switch core 0 -> core 2
      sample_clk = 1'b0; sel_core = 2'd2; sel_valid = 1'b1; step();
      sel_valid = 1'b0;
      tick_n(1);
      check_eq("fo_tick1", int'($signed(so0)), 984);
      tick_n(63);
      check_eq("fo_tick64", int'($signed(so0)), 0);
      tick_n(1);
      check_eq("swap_core", int'(active_core), 2);
      check_eq("fi_tick1", int'($signed(so0)), -32);
      tick_n(63);
      check_eq("fi_tick64", int'($signed(so1)), -2000);
      check_eq("fi_busy", int'(busy), 0);

      // Accept coinciding with a tick uses the old core unscaled
      sample_clk = 1'b0; step();
      sample_clk = 1'b1; sel_valid = 1'b1; sel_core = 2'd0; step();
      sel_valid = 1'b0;
      check_eq("tick_accept", int'($signed(so2)), -2000);
      tick_n(1);
      check_eq("tick_accept_next", int'($signed(so2)), -1969);
      tick_n(63);
      tick_n(64);
      check_eq("back_core0", int'(active_core), 0);
      check_eq("back_out", int'($signed(so3)), 1000);

      // Request held through a fade is only taken once back in RUN
      a0 = m_accepts;
      sample_clk = 1'b0; sel_core = 2'd2; sel_valid = 1'b1; step();
      sel_core = 2'd1;
      for (int i = 0; i < 2000 && m_accepts < a0 + 2; i++) begin
         sample_clk = ~sample_clk; step();
      end
      sel_valid = 1'b0;
      check_eq("held_in_fade", int'(busy), 1);
      wait_idle();
      check_eq("held_core1", int'(active_core), 1);
      check_eq("held_out1", int'($signed(so1)), -300);

      // Same-core and out-of-range requests are consumed without a fade
      sample_clk = 1'b0; sel_valid = 1'b1; sel_core = 2'd1; step();
      check_eq("same_busy", int'(busy), 0);
      sel_core = 2'd3; step();
      check_eq("bad_busy", int'(busy), 0);
      sel_valid = 1'b0; step();
      check_eq("ignored_core", int'(active_core), 1);

      // Asynchronous reset 30 ticks into a fade-out
      sel_valid = 1'b1; sel_core = 2'd2; step();
      sel_valid = 1'b0;
      tick_n(30);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_out", int'($signed(so1)), 0);
      check_eq("arst_core", int'(active_core), 0);
      check_eq("arst_busy", int'(busy), 1);
      check_eq("arst_ready", int'(sel_ready), 0);
      model_reset();
      sample_clk = 1'b0; step();
      rst = 1'b0;
      tick_n(1);
      check_eq("arst_first_tick", int'($signed(so0)), 15);
      tick_n(63);
      check_eq("arst_refade", int'($signed(so0)), 1000);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         sample_clk = 1'($urandom_range(0, 1));
         sel_valid  = ($urandom_range(0, 9) == 0);
         sel_core   = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) begin
            case ($urandom_range(0, 3))
               0:       vals[$urandom_range(0, NC-1)][$urandom_range(0, 3)] = -16'sd32768;
               1:       vals[$urandom_range(0, NC-1)][$urandom_range(0, 3)] = 16'sd32767;
               default: vals[$urandom_range(0, NC-1)][$urandom_range(0, 3)] = 16'($urandom);
            endcase
         end
         step();
      end
      sel_valid = 1'b0;
      wait_idle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
